al422b_2rgb_8s: RTL and testbench

- HUB75-style LED panel driver for 1/8 scan with two RGB channels (upper/lower half), fed from an AL422B video FIFO.
- The FIFO read side advances one byte per in_clk, continuously, with no read enable.
- The block rewinds the FIFO once per frame via al422_nrst, shifts pixel data to the panel, latches each row, and selects the row address.

---
 rtl/al422b_2rgb_8s.sv | 121 ++++++++++++
 tb/tb_al422b_2rgb_8s.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/al422b_2rgb_8s.sv
`timescale 1ns/1ps
// HUB75 1/8-scan dual-RGB panel driver streaming pixels from an AL422B FIFO.
// The FIFO is rewound once per frame so row r, cycle c always reads address r*ROW_CYCLES+c.
module al422b_2rgb_8s #(
    parameter int COLS       = 32,
    parameter int ROW_CYCLES = 256
) (
    input  logic       in_clk,
    input  logic       in_nrst,
    input  logic [7:0] in_data,
    output logic       al422_nrst,
    output logic       led_clk_out,
    output logic       led_lat_out,
    output logic       led_oe_out,
    output logic [4:0] led_row,
    output logic [2:0] rgb1,
    output logic [2:0] rgb2
);

    localparam int CW = $clog2(ROW_CYCLES);

    localparam logic [CW-1:0] C_LAST  = CW'(ROW_CYCLES - 1);
    localparam logic [CW-1:0] C_PRE   = CW'(ROW_CYCLES - 2);
    localparam logic [CW-1:0] C_EDGE  = CW'(2 * COLS);
    localparam logic [CW-1:0] C_BLANK = CW'(2 * COLS + 1);
    localparam logic [CW-1:0] C_LAT   = CW'(2 * COLS + 2);
    localparam logic [CW-1:0] C_ROW   = CW'(2 * COLS + 3);
    localparam logic [CW-1:0] C_SHOW  = CW'(2 * COLS + 4);

    logic [CW-1:0] c_q, c_d;
    logic [2:0]    row_q, row_d;
    logic [2:0]    temp_q, temp_d;
    logic [2:0]    rgb1_q, rgb1_d;
    logic [2:0]    rgb2_q, rgb2_d;
    logic [2:0]    lrow_q, lrow_d;
    logic          clk_q, clk_d;
    logic          lat_q, lat_d;
    logic          oe_q, oe_d;
    logic          nrst_q, nrst_d;

    always_ff @(posedge in_clk or negedge in_nrst) begin
        if (!in_nrst) begin
            c_q    <= '0;
            row_q  <= '0;
            temp_q <= '0;
            rgb1_q <= '0;
            rgb2_q <= '0;
            lrow_q <= '0;
            clk_q  <= 1'b0;
            lat_q  <= 1'b0;
            oe_q   <= 1'b1;
            nrst_q <= 1'b0;
        end else begin
            c_q    <= c_d;
            row_q  <= row_d;
            temp_q <= temp_d;
            rgb1_q <= rgb1_d;
            rgb2_q <= rgb2_d;
            lrow_q <= lrow_d;
            clk_q  <= clk_d;
            lat_q  <= lat_d;
            oe_q   <= oe_d;
            nrst_q <= nrst_d;
        end
    end

    always_comb begin
        c_d    = c_q + 1'b1;
        row_d  = row_q;
        temp_d = temp_q;
        rgb1_d = rgb1_q;
        rgb2_d = rgb2_q;
        lrow_d = lrow_q;
        clk_d  = clk_q;
        lat_d  = lat_q;
        oe_d   = oe_q;

        if (c_q == C_LAST) begin
            c_d   = '0;
            row_d = row_q + 1'b1;
        end

        // Pulse lands in the last cycle of row 7, so row 0 reads address 0.
        nrst_d = !((row_q == 3'd7) && (c_q == C_PRE));

        if (c_q < C_EDGE) begin
            if (!c_q[0]) begin
                temp_d = in_data[2:0];
                clk_d  = (c_q != '0);
            end else begin
                rgb1_d = temp_q;
                rgb2_d = in_data[2:0];
                clk_d  = 1'b0;
            end
        end else begin
            case (c_q)
                C_EDGE:  clk_d = 1'b1;
                C_BLANK: begin
                    clk_d = 1'b0;
                    oe_d  = 1'b1;
                end
                C_LAT:   lat_d = 1'b1;
                C_ROW:   begin
                    lat_d  = 1'b0;
                    lrow_d = row_q;
                end
                C_SHOW:  oe_d = 1'b0;
                default: ;
            endcase
        end
    end

    assign al422_nrst  = nrst_q;
    assign led_clk_out = clk_q;
    assign led_lat_out = lat_q;
    assign led_oe_out  = oe_q;
    assign led_row     = {2'b00, lrow_q};
    assign rgb1        = rgb1_q;
    assign rgb2        = rgb2_q;

endmodule

// File: tb/tb_al422b_2rgb_8s.sv
`timescale 1ns/1ps
// Bench for al422b_2rgb_8s: FIFO model plus address-level reference of the scan timing.
module tb_al422b_2rgb_8s;

    localparam int COLS = 32;
    localparam int RC   = 256;

    logic       in_clk;
    logic       in_nrst;
    logic [7:0] in_data;
    logic       al422_nrst;
    logic       led_clk_out;
    logic       led_lat_out;
    logic       led_oe_out;
    logic [4:0] led_row;
    logic [2:0] rgb1;
    logic [2:0] rgb2;

    al422b_2rgb_8s #(.COLS(COLS), .ROW_CYCLES(RC)) dut (
        .in_clk      (in_clk),
        .in_nrst     (in_nrst),
        .in_data     (in_data),
        .al422_nrst  (al422_nrst),
        .led_clk_out (led_clk_out),
        .led_lat_out (led_lat_out),
        .led_oe_out  (led_oe_out),
        .led_row     (led_row),
        .rgb1        (rgb1),
        .rgb2        (rgb2)
    );

    initial begin
        in_clk = 1'b0;
        forever #5 in_clk = ~in_clk;
    end

    logic [7:0]  mem [2048];
    logic [31:0] faddr;
    bit          started;
    int          n;
    int          n_assert;
    int          n_fail;
    logic        prev_clk;
    logic        prev_lat;
    int          ecnt;
    int          lcnt;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)",
                   tag, obs, exp, n);
        end
    endtask

    task automatic reset_phase();
        in_nrst = 1'b0;
        #1;
        chk("rst_al422_nrst", 32'(al422_nrst), 32'd0);
        chk("rst_clk", 32'(led_clk_out), 32'd0);
        chk("rst_lat", 32'(led_lat_out), 32'd0);
        chk("rst_oe", 32'(led_oe_out), 32'd1);
        chk("rst_row", 32'(led_row), 32'd0);
        chk("rst_rgb1", 32'(rgb1), 32'd0);
        chk("rst_rgb2", 32'(rgb2), 32'd0);
        @(negedge in_clk);
        in_nrst  = 1'b1;
        n        = 0;
        faddr    = 32'd0;
        started  = 1'b0;
        prev_clk = 1'b0;
        prev_lat = 1'b0;
        ecnt     = 0;
        lcnt     = 0;
        in_data  = mem[0];
    endtask

    task automatic check_cycle();
        int g, row, c, lo, rr, nr, nc;
        logic [2:0] e1, e2;
        logic [2:0] erow;
        g   = n - 1;
        row = (g / RC) % 8;
        c   = g % RC;

        chk("clk", 32'(led_clk_out),
            32'((c % 2 == 0) && c >= 2 && c <= 2 * COLS));
        chk("lat", 32'(led_lat_out), 32'(c == 2 * COLS + 2));
        chk("oe", 32'(led_oe_out),
            32'((c >= 2 * COLS + 1 && c <= 2 * COLS + 3) || g < 2 * COLS + 4));

        if (g < 2 * COLS + 3) erow = 3'd0;
        else if (c >= 2 * COLS + 3) erow = 3'(row);
        else erow = 3'((row + 7) % 8);
        chk("led_row", 32'(led_row), 32'(erow));

        if (g == 0) begin
            e1 = 3'd0;
            e2 = 3'd0;
        end else begin
            if (c >= 2 * COLS - 1) begin
                lo = 2 * COLS - 1;
                rr = row;
            end else if (c >= 1) begin
                lo = (c % 2 == 1) ? c : c - 1;
                rr = row;
            end else begin
                lo = 2 * COLS - 1;
                rr = (row + 7) % 8;
            end
            e1 = mem[rr * RC + lo - 1][2:0];
            e2 = mem[rr * RC + lo][2:0];
        end
        chk("rgb1", 32'(rgb1), 32'(e1));
        chk("rgb2", 32'(rgb2), 32'(e2));

        nr = (n / RC) % 8;
        nc = n % RC;
        chk("al422_nrst", 32'(al422_nrst), 32'(!(nr == 7 && nc == RC - 1)));
        if (n % (8 * RC) == 0) chk("rewind_addr", faddr, 32'd0);

        if (led_clk_out && !prev_clk) ecnt++;
        if (led_lat_out && !prev_lat) lcnt++;
        prev_clk = led_clk_out;
        prev_lat = led_lat_out;
        if (c == RC - 1) begin
            chk("edges_per_row", 32'(ecnt), 32'(COLS));
            chk("lats_per_row", 32'(lcnt), 32'd1);
            ecnt = 0;
            lcnt = 0;
        end
    endtask

    task automatic step();
        logic rec;
        rec = al422_nrst;
        @(posedge in_clk);
        #1;
        faddr   = (!rec && started) ? 32'd0 : faddr + 32'd1;
        started = 1'b1;
        n++;
        in_data = mem[faddr[10:0]];
        check_cycle();
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        n        = 0;
        faddr    = 32'd0;
        in_nrst  = 1'b0;
        in_data  = 8'h00;

        // Uniform 0x02 over two full frames.
        for (int i = 0; i < 2048; i++) mem[i] = 8'h02;
        #15;
        reset_phase();
        for (int i = 0; i < 2 * 8 * RC + 16; i++) begin
            step();
            if (n - 1 == 10) begin
                chk("uniform_rgb1", 32'(rgb1), 32'd2);
                chk("uniform_rgb2", 32'(rgb2), 32'd2);
            end
        end

        // Sparse pixel-mapping pattern.
        for (int i = 0; i < 2048; i++) mem[i] = 8'h00;
        mem[0]  = 8'h05;
        mem[1]  = 8'h03;
        mem[63] = 8'hFF;
        reset_phase();
        for (int i = 0; i < 8 * RC + 8; i++) begin
            step();
            if (n - 1 == 2) begin
                chk("first_edge_rgb1", 32'(rgb1), 32'd5);
                chk("first_edge_rgb2", 32'(rgb2), 32'd3);
            end
            if (n - 1 == 2 * COLS) begin
                chk("last_edge_rgb1", 32'(rgb1), 32'd0);
                chk("last_edge_rgb2", 32'(rgb2), 32'd7);
            end
        end

        // Random data, reset mid-row at row 3 c=40, then two more frames.
        for (int i = 0; i < 2048; i++) mem[i] = 8'($urandom);
        reset_phase();
        for (int i = 0; i < 3 * RC + 40; i++) step();
        #2;
        reset_phase();
        for (int i = 0; i < 2 * 8 * RC + 100; i++) step();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
